hs32_mem_arbiter: RTL
=====================

Name: hs32_mem_arbiter

Overview:
- Two-master arbiter directly upstream of the byte-lane BRAM controller.
- Master 0 is the HS32 CPU data port; master 1 is the management-SoC Wishbone bridge.
- Selects one request, registers its address, write data and rw, and issues a single strobe to the BRAM controller.
- Holds the address stable until the controller acks, then returns registered read data and a one-cycle ack to the granted master.
- A watchdog terminates a transaction if the slave ack never arrives.

Parameters:
- AW, 12, byte address width, passed through to the BRAM controller address port.
- TIMEOUT, 15, number of cycles in WAIT without s_ack before forced completion; 4-bit counter, legal range 2..15.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous active-high reset
- m0_stb  input  1  CPU request; level, held until m0_ack
- m0_rw  input  1  1 = write, 0 = read
- m0_addr  input  AW  CPU byte address (may be unaligned)
- m0_dwrite  input  32  CPU write data
- m0_ack  output  1  one-cycle completion pulse
- m0_err  output  1  valid with m0_ack; 1 = watchdog timeout
- m0_dread  output  32  read data, valid while m0_ack=1
- m1_stb, m1_rw, m1_addr, m1_dwrite, m1_ack, m1_err, m1_dread: same as master 0, for the Wishbone bridge
- s_stb  output  1  strobe to the BRAM controller, one-cycle pulse
- s_rw  output  1  registered rw
- s_addr  output  AW  registered address, stable from the S_REQ cycle through the s_ack cycle
- s_dwrite  output  32  registered write data
- s_ack  input  1  controller ack
- s_dread  input  32  controller read data, sampled only in the cycle s_ack=1
- o_grant  output  1  currently or last granted master, 0 or 1 (debug)

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - All outputs, registered address/data/rw, response data, watchdog counter and o_grant clear to 0.
  - In-flight transactions are dropped; no ack is issued for them.
  - Reset asserted mid-transaction overrides everything on that edge.
- States: IDLE, S_REQ, WAIT, RESP (2-bit encoding).
- IDLE:
  - If any mN_stb is high, choose the winner, latch its addr/dwrite/rw into s_addr/s_dwrite/s_rw, set o_grant, go to S_REQ.
  - Otherwise stay in IDLE.
- Arbitration is round-robin:
  - Single requester wins.
  - If both request, the master that was NOT the last grant wins. After reset, the last grant is 1, so master 0 wins the first tie.
- S_REQ:
  - s_stb=1 for exactly this cycle.
  - Clear the watchdog counter.
  - Next state is WAIT.
- WAIT:
  - s_stb=0; s_addr/s_rw/s_dwrite held.
  - On s_ack=1: capture s_dread into the response register (0 for writes), err=0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 with no ack: response data = 32'hFFFF_FFFF, err=1, go to RESP.
  - s_ack in the same cycle as the timeout: the ack wins, err=0.
- RESP:
  - mG_ack=1 for exactly one cycle, where G = o_grant, with mG_dread and mG_err driven from the response register.
  - The other master's ack, err and dread stay 0.
  - Next state is IDLE; mN_stb is not sampled in this cycle.
- Master rule: drop stb in the cycle after its ack, or re-request; a re-request is treated as a new transaction.
- Latency: stb sampled at edge 0, s_stb in cycle 1, earliest s_ack in cycle 2, m_ack in cycle 3.
  - Minimum of 3 cycles stb-to-ack with the BRAM controller's 1-cycle ack; 4-cycle minimum turnaround per transaction.
- Ungranted master: its stb and inputs are ignored and it simply waits. Its inputs may change while waiting; values are sampled only at grant.
- Spurious s_ack outside WAIT is ignored.
- Counter width is 4 bits and it never wraps; it is cleared in S_REQ.

Test Plan:
- M0 read only: m0_addr=12'h005, slave returns s_dread=32'h1122_3344 one cycle after s_stb.
  -> s_addr=12'h005 held through the ack cycle; m0_ack in cycle 3; m0_dread=32'h1122_3344; m0_err=0; m1_ack stays 0.
- M1 write: m1_rw=1, m1_addr=12'h0FF, m1_dwrite=32'hDEAD_BEEF.
  -> s_stb single pulse with s_rw=1, s_dwrite=32'hDEAD_BEEF; m1_ack one cycle; m1_dread=0.
- Both masters request continuously from reset, 4 transactions.
  -> grant order 0,1,0,1; each ack goes only to the granted master; no back-to-back grants to the same master.
- Slave never acks, TIMEOUT=15.
  -> m0_ack exactly 16 cycles after s_stb, with m0_err=1 and m0_dread=32'hFFFF_FFFF; arbiter returns to IDLE and serves the next request normally.
- Reset asserted in WAIT after s_stb.
  -> next cycle all outputs are 0 and state is IDLE; a late s_ack is ignored; no m_ack is produced.
- s_ack arriving in the same cycle as the timeout.
  -> err=0 and the captured s_dread is returned.

Source files
------------

// File: rtl/hs32_mem_arbiter.sv
// Two-master round-robin arbiter in front of the byte-lane BRAM controller.
// One transaction in flight at a time, with a watchdog that forces an error response.
module hs32_mem_arbiter #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          m0_stb,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_dwrite,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [31:0]   m0_dread,
  input  logic          m1_stb,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_dwrite,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [31:0]   m1_dread,
  output logic          s_stb,
  output logic          s_rw,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   s_dwrite,
  input  logic          s_ack,
  input  logic [31:0]   s_dread,
  output logic          o_grant
);

  typedef enum logic [1:0] {IDLE, S_REQ, WAIT, RESP} state_t;

  localparam logic [3:0] WDOG_LAST = 4'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          r_grant;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_dwrite;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [3:0]    r_wdog;
  logic          w_any_req;
  logic          w_winner;
  logic          w_resp;

  assign w_any_req = m0_stb | m1_stb;
  // On a tie the master that did not win last time goes first.
  assign w_winner  = (m0_stb && m1_stb) ? ~r_last : m1_stb;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = S_REQ;
      S_REQ:   w_next = WAIT;
      WAIT:    if (s_ack || (r_wdog == WDOG_LAST)) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: every register here is clocked state, so only non-blocking assignments;
  // the last-grant flag resets to 1 so master 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_dwrite <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_wdog   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_winner;
            r_last   <= w_winner;
            r_rw     <= w_winner ? m1_rw     : m0_rw;
            r_addr   <= w_winner ? m1_addr   : m0_addr;
            r_dwrite <= w_winner ? m1_dwrite : m0_dwrite;
          end
        end
        S_REQ: r_wdog <= '0;
        WAIT: begin
          if (s_ack) begin
            r_rdata <= r_rw ? 32'h0 : s_dread;
            r_err   <= 1'b0;
          end else if (r_wdog == WDOG_LAST) begin
            r_rdata <= 32'hFFFF_FFFF;
            r_err   <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_resp   = (r_state == RESP);
  assign s_stb    = (r_state == S_REQ);
  assign s_rw     = r_rw;
  assign s_addr   = r_addr;
  assign s_dwrite = r_dwrite;
  assign o_grant  = r_grant;

  assign m0_ack   = w_resp & ~r_grant;
  assign m0_err   = m0_ack & r_err;
  assign m0_dread = m0_ack ? r_rdata : 32'h0;
  assign m1_ack   = w_resp & r_grant;
  assign m1_err   = m1_ack & r_err;
  assign m1_dread = m1_ack ? r_rdata : 32'h0;

endmodule
